// File: rtl/ring_decoder.sv
// ring_decoder -- tracks a one-hot ring counter and reports its position,
// the direction of each step, completed laps and protocol faults.
//
// Optional feature macro: RING_DEC_SYNC_EN
//   defined   : cnt_in passes through a 2-flop synchronizer before s_q
//               (cnt_in to output latency is 4 mclk)
//   undefined : cnt_in feeds s_q directly (latency is 2 mclk)
//
// state | meaning
// IDLE  | no reference pattern yet, waiting for the first one-hot sample
// TRACK | locked to prev, accepting single adjacent steps
// FAULT | protocol fault seen, err sticky, cnt_in ignored until clr_err

module ring_decoder (
    input  logic       mclk,
    input  logic       rst,
    input  logic [7:0] cnt_in,
    input  logic       clr_err,
    output logic [2:0] pos,
    output logic       valid,
    output logic       dir,
    output logic       step,
    output logic [7:0] lap_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] s_in;
    logic [7:0] s_q;
    logic [7:0] prev_q;
    logic [7:0] prev_d;

    logic [2:0] pos_d;
    logic       dir_d;
    logic       step_d;
    logic       valid_d;
    logic       err_d;
    logic [7:0] lap_d;

    logic [2:0] s_idx;
    logic [2:0] prev_idx;
    logic [2:0] prev_up;
    logic [2:0] prev_dn;
    logic       s_zero;
    logic       s_onehot;
    logic       is_same;
    logic       is_up;
    logic       is_down;
    logic       lap_max;

    // Binary index of the highest set bit; only meaningful for one-hot input.
    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

    // Exactly one bit set.
    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

`ifdef RING_DEC_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    // Two-flop synchronizer for an asynchronous ring counter source.
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
        end else begin
            sync1_q <= cnt_in;
            sync2_q <= sync1_q;
        end
    end

    assign s_in = sync2_q;
`else
    assign s_in = cnt_in;
`endif

    // Sample register: all decoding works from s_q, never from cnt_in.
    always_ff @(posedge mclk) begin
        if (rst) begin
            s_q <= 8'd0;
        end else begin
            s_q <= s_in;
        end
    end

    assign s_idx    = enc8(s_q);
    assign prev_idx = enc8(prev_q);
    assign prev_up  = prev_idx + 3'd1;
    assign prev_dn  = prev_idx - 3'd1;
    assign s_zero   = (s_q == 8'd0);
    assign s_onehot = onehot8(s_q);
    assign is_same  = (s_q == prev_q);
    assign is_up    = s_onehot && (s_idx == prev_up);
    assign is_down  = s_onehot && (s_idx == prev_dn);
    assign lap_max  = (lap_cnt == 8'hFF);

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        pos_d   = pos;
        dir_d   = dir;
        step_d  = 1'b0;
        valid_d = valid;
        err_d   = err;
        lap_d   = lap_cnt;

        if (clr_err) begin
            // Clear wins over whatever s_q holds this cycle; that sample is dropped.
            state_d = IDLE;
            valid_d = 1'b0;
            err_d   = 1'b0;
            lap_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (s_onehot) begin
                        state_d = TRACK;
                        prev_d  = s_q;
                        pos_d   = s_idx;
                        valid_d = 1'b1;
                    end else if (!s_zero) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end

                TRACK: begin
                    valid_d = 1'b1;
                    if (is_same) begin
                        state_d = TRACK;
                    end else if (is_up) begin
                        prev_d = s_q;
                        pos_d  = s_idx;
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                        if ((prev_idx == 3'd7) && !lap_max) begin
                            lap_d = lap_cnt + 8'd1;
                        end
                    end else if (is_down) begin
                        prev_d = s_q;
                        pos_d  = s_idx;
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                        if ((prev_idx == 3'd0) && !lap_max) begin
                            lap_d = lap_cnt + 8'd1;
                        end
                    end else begin
                        // Zero, multi-hot or a skipped position.
                        state_d = FAULT;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end

                FAULT: begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end

                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, reference pattern and registered outputs.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= 8'd0;
            pos     <= 3'd0;
            dir     <= 1'b0;
            step    <= 1'b0;
            valid   <= 1'b0;
            lap_cnt <= 8'd0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pos     <= pos_d;
            dir     <= dir_d;
            step    <= step_d;
            valid   <= valid_d;
            lap_cnt <= lap_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder -- directed-vector bench for ring_decoder.

module tb_ring_decoder;

`ifdef RING_DEC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       mclk;
    logic       rst;
    logic [7:0] cnt_in;
    logic       clr_err;
    logic [2:0] pos;
    logic       valid;
    logic       dir;
    logic       step;
    logic [7:0] lap_cnt;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;
    int step_seen = 0;
    int step_base;

    ring_decoder dut (
        .mclk    (mclk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .clr_err (clr_err),
        .pos     (pos),
        .valid   (valid),
        .dir     (dir),
        .step    (step),
        .lap_cnt (lap_cnt),
        .err     (err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Step pulses counted on the falling edge, away from the active edge.
    always @(negedge mclk) begin
        if (step === 1'b1) begin
            step_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic put(input logic [7:0] v);
        cnt_in = v;
        tick(LAT);
    endtask

    initial begin
        rst     = 1'b1;
        clr_err = 1'b0;
        cnt_in  = 8'h01;
        tick(3);
        chk("rst_pos",   pos,     0);
        chk("rst_valid", valid,   0);
        chk("rst_step",  step,    0);
        chk("rst_dir",   dir,     0);
        chk("rst_lap",   lap_cnt, 0);
        chk("rst_err",   err,     0);

        // First one-hot sample enters TRACK without a step.
        rst = 1'b0;
        tick(LAT);
        chk("lock_valid", valid, 1);
        chk("lock_pos",   pos,   0);
        chk("lock_step",  step,  0);
        chk("lock_err",   err,   0);

        // Up sweep 0x01 -> 0x80 -> 0x01, each pattern held 4 cycles.
        step_base = step_seen;
        for (int i = 1; i <= 8; i++) begin
            cnt_in = 8'h01 << (i % 8);
            tick(LAT);
            chk("up_step", step,    1);
            chk("up_dir",  dir,     0);
            chk("up_pos",  pos,     i % 8);
            chk("up_lap",  lap_cnt, (i == 8) ? 1 : 0);
            tick(4 - LAT > 0 ? 4 - LAT : 1);
            chk("up_hold_step", step, 0);
        end
        chk("up_step_count", step_seen - step_base, 8);

        // Down steps through the 0 -> 7 wrap.
        put(8'h80);
        chk("dn_step", step,    1);
        chk("dn_dir",  dir,     1);
        chk("dn_pos",  pos,     7);
        chk("dn_lap",  lap_cnt, 2);
        put(8'h40);
        chk("dn2_pos", pos,     6);
        chk("dn2_dir", dir,     1);
        chk("dn2_lap", lap_cnt, 2);

        // Reversal 6 -> 5 -> 6 is two legal steps.
        put(8'h20);
        chk("rev1_pos", pos, 5);
        chk("rev1_dir", dir, 1);
        put(8'h40);
        chk("rev2_pos",  pos,  6);
        chk("rev2_dir",  dir,  0);
        chk("rev2_step", step, 1);
        chk("rev2_err",  err,  0);

        put(8'h20);
        put(8'h10);
        put(8'h08);
        put(8'h04);
        chk("at2_pos", pos, 2);
        chk("at2_dir", dir, 1);

        // Skip 0x04 -> 0x10 faults; later samples ignored.
        put(8'h10);
        chk("skip_err",   err,     1);
        chk("skip_valid", valid,   0);
        chk("skip_pos",   pos,     2);
        chk("skip_step",  step,    0);
        chk("skip_lap",   lap_cnt, 2);
        put(8'h08);
        chk("ign_err", err, 1);
        chk("ign_pos", pos, 2);

        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_err",   err,     0);
        chk("clr_lap",   lap_cnt, 0);
        chk("clr_valid", valid,   0);
        chk("clr_pos",   pos,     2);
        chk("clr_dir",   dir,     1);
        tick(1);
        chk("relock_valid", valid, 1);
        chk("relock_pos",   pos,   3);
        chk("relock_step",  step,  0);

        // Zero pattern in TRACK faults; zero in IDLE just waits.
        put(8'h00);
        chk("zero_err",   err,   1);
        chk("zero_valid", valid, 0);
        chk("zero_pos",   pos,   3);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(2);
        chk("idle0_err",   err,   0);
        chk("idle0_valid", valid, 0);
        put(8'h08);
        chk("relock2_valid", valid, 1);
        chk("relock2_step",  step,  0);

        // clr_err coincident with a multi-hot sample: the sample is dropped.
        cnt_in = 8'h03;
        tick(LAT - 1);
        clr_err = 1'b1;
        cnt_in  = 8'h10;
        tick(1);
        clr_err = 1'b0;
        chk("coinc_err",   err,   0);
        chk("coinc_valid", valid, 0);
        tick(1);
        chk("coinc_track_valid", valid, 1);
        chk("coinc_track_pos",   pos,   4);
        chk("coinc_track_step",  step,  0);
        chk("coinc_track_err",   err,   0);

        // 255 up laps, one step per cycle.
        for (int k = 0; k < 2040; k++) begin
            cnt_in = 8'h01 << ((5 + k) % 8);
            tick(1);
        end
        tick(LAT);
        chk("lap255",       lap_cnt, 255);
        chk("lap255_pos",   pos,     4);
        chk("lap255_err",   err,     0);
        chk("lap255_valid", valid,   1);

        // One more lap must not wrap the counter.
        for (int k = 2040; k < 2048; k++) begin
            cnt_in = 8'h01 << ((5 + k) % 8);
            tick(1);
        end
        tick(LAT);
        chk("lap_sat",     lap_cnt, 255);
        chk("lap_sat_pos", pos,     4);
        chk("lap_sat_err", err,     0);

        // Reset mid-lap discards history.
        cnt_in = 8'h20;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mrst_pos",   pos,     0);
        chk("mrst_valid", valid,   0);
        chk("mrst_lap",   lap_cnt, 0);
        chk("mrst_step",  step,    0);
        chk("mrst_err",   err,     0);
        rst = 1'b0;
        tick(LAT);
        chk("prst_valid", valid,   1);
        chk("prst_pos",   pos,     5);
        chk("prst_step",  step,    0);
        chk("prst_lap",   lap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ring_decoder.md
RING_DECODER -- requirements
Module: ring_decoder

Interface
REQ-001 SHALL have no parameters; all widths fixed (8-bit ring, 3-bit position, 8-bit lap counter).
REQ-002 mclk  input  1  system clock; all flops on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cnt_in  input  8  one-hot ring pattern from the ring counter, stepping left (mode 0) or right (mode 1).
REQ-005 clr_err  input  1  single-cycle clear: drops err, zeroes lap_cnt, returns FSM to IDLE.
REQ-006 pos  output  3  binary index of the set bit in the last valid pattern (bit0=0 ... bit7=7).
REQ-007 valid  output  1  high while the FSM is in TRACK.
REQ-008 dir  output  1  direction of the last step: 0 = left/up (index+1), 1 = right/down (index-1).
REQ-009 step  output  1  one-mclk pulse per accepted adjacent step.
REQ-010 lap_cnt  output  8  completed wraps (7->0 up or 0->7 down); saturates at 255.
REQ-011 err  output  1  sticky protocol-fault flag.

Function
REQ-012 cnt_in SHALL be registered into sample register s_q each mclk; decode uses s_q and prev (last accepted pattern).
REQ-013 Outputs SHALL be registered; latency from cnt_in change to pos/step/dir/lap_cnt/valid/err = 2 mclk (macro off).
REQ-014 FSM states SHALL be IDLE, TRACK, FAULT.
REQ-015 IDLE: s_q one-hot -> TRACK, pos/prev loaded, valid=1, no step; s_q==0 -> stay IDLE; s_q multi-hot -> FAULT.
REQ-016 TRACK, s_q==prev: hold all outputs, step=0.
REQ-017 TRACK, s_q one-hot at index prev+1 mod 8: pos updated, dir=0, step=1 for one cycle.
REQ-018 TRACK, s_q one-hot at index prev-1 mod 8: pos updated, dir=1, step=1 for one cycle.
REQ-019 Step 7->0 (dir=0) or 0->7 (dir=1) SHALL also increment lap_cnt, same cycle as step; at 255 lap_cnt holds.
REQ-020 TRACK, s_q zero, multi-hot, or one-hot non-adjacent (skip) -> FAULT; no step, no lap increment.
REQ-021 Direction reversal (e.g. index 3->4->3) SHALL be accepted as two steps with dir following each step; no fault.
REQ-022 FAULT: err=1, valid=0, step=0; pos, dir, lap_cnt hold last values; ignore cnt_in until clr_err.
REQ-023 clr_err in any state: next cycle err=0, lap_cnt=0, state=IDLE, valid=0; pos and dir hold.
REQ-024 clr_err coincident with a faulting sample: clr_err wins; that sample is discarded, next sample evaluated from IDLE.
REQ-025 step and an err rising edge SHALL never assert in the same cycle.

Reset
REQ-026 rst SHALL override clr_err and all inputs, synchronously on the mclk edge.
REQ-027 Reset values: state=IDLE, s_q=0, prev=0, pos=0, dir=0, step=0, valid=0, lap_cnt=0, err=0.
REQ-028 rst mid-TRACK or mid-FAULT SHALL discard history; first post-reset one-hot sample enters TRACK without a step.

Configuration
REQ-029 Macro RING_DEC_SYNC_EN: when defined, cnt_in SHALL pass through an extra 2-flop synchronizer ahead of s_q; latency becomes 4 mclk; sync flops reset to 0.
REQ-030 Without RING_DEC_SYNC_EN, cnt_in feeds s_q directly; latency 2 mclk; all other behaviour identical.

Verification
REQ-031 rst, then cnt_in=0x01 held -> valid=1, pos=0, step=0, err=0 after latency.
REQ-032 cnt_in 0x01,0x02,...,0x80,0x01 (each held 4 mclk) -> 8 step pulses, dir=0, pos 0..7..0, lap_cnt=1 at 0x80->0x01.
REQ-033 From pos=0 in TRACK, cnt_in 0x80,0x40 -> dir=1, pos 7 then 6, lap_cnt+1 on 0x01->0x80.
REQ-034 TRACK at 0x04, cnt_in=0x10 (skip) -> err=1, valid=0, pos stays 2; later 0x08 ignored; clr_err pulse -> err=0, lap_cnt=0, then 0x08 -> valid=1, pos=3, no step.
REQ-035 TRACK, cnt_in=0x00 or 0x03 -> FAULT; same cycle clr_err and 0x03 -> err stays 0, IDLE.
REQ-036 Force 256 up-laps -> lap_cnt saturates at 255; rst mid-lap -> all outputs to reset values next edge.
